decodificador_pwm: RTL and testbench

Receive-side counterpart of the servo PWM generator. Samples an external PWM line, measures high time and period in clock cycles, and maps the high time to the 3-bit width code. Used on the board-to-board link and in loopback self-test against the generator. Flags out-of-tolerance pulses, bad periods and signal loss.

---
 rtl/decodificador_pwm_if.sv | 20 ++
 rtl/decodificador_pwm.sv | 139 +++++++++++++
 tb/tb_decodificador_pwm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decodificador_pwm_if.sv
// Bundles the sampled PWM line with the decoder's result signals.
interface decodificador_pwm_if;
  logic        pwm_in;
  logic [2:0]  largura;
  logic        valido;
  logic        pronto;
  logic        erro;
  logic [31:0] medida;
  logic        perda_sinal;

  modport master (
    output pwm_in,
    input  largura, valido, pronto, erro, medida, perda_sinal
  );

  modport slave (
    input  pwm_in,
    output largura, valido, pronto, erro, medida, perda_sinal
  );
endinterface

// File: rtl/decodificador_pwm.sv
// Measures high time and period of a synchronized PWM line and decodes the high time into a 3-bit width code.
// Results update 3 edges after the closing rise of pwm_in; there is no backpressure, so pronto is a bare one-cycle pulse.
module decodificador_pwm #(
  parameter logic [31:0] conf_periodo = 32'd1000000,
  parameter logic [31:0] tol_periodo  = 32'd10000,
  parameter logic [31:0] largura_000  = 32'd35000,
  parameter logic [31:0] largura_001  = 32'd45700,
  parameter logic [31:0] largura_010  = 32'd56450,
  parameter logic [31:0] largura_011  = 32'd67150,
  parameter logic [31:0] largura_100  = 32'd77850,
  parameter logic [31:0] largura_101  = 32'd88550,
  parameter logic [31:0] largura_110  = 32'd99300,
  parameter logic [31:0] largura_111  = 32'd110000,
  parameter logic [31:0] tolerancia   = 32'd2000,
  parameter logic [31:0] timeout      = 32'd2000000
) (
  input logic               clock,
  input logic               reset,
  decodificador_pwm_if.slave bus
);

  typedef enum logic [1:0] {INICIAL, ALTO, BAIXO} estado_t;

  localparam logic [31:0] larguras [8] = '{largura_000, largura_001, largura_010, largura_011,
                                           largura_100, largura_101, largura_110, largura_111};

  estado_t     estado;
  logic        s1, s2, s3;
  logic [31:0] cont_alto, cont_periodo;
  logic [2:0]  largura;
  logic        valido, pronto, erro, perda_sinal;
  logic [31:0] medida;

  logic       rise, fall;
  logic       periodo_ok, casou;
  logic [2:0] codigo;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  function automatic logic [31:0] inc_sat(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  // Signed 33-bit difference so a count below the nominal value cannot wrap.
  function automatic logic [32:0] dif_abs(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Nominal widths are spaced by more than twice the tolerance, so at most one code can match.
  always_comb begin
    periodo_ok = dif_abs(cont_periodo, conf_periodo) <= {1'b0, tol_periodo};
    casou      = 1'b0;
    codigo     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (dif_abs(cont_alto, larguras[k]) <= {1'b0, tolerancia}) begin
        casou  = 1'b1;
        codigo = 3'(k);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIAL;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cont_alto    <= '0;
      cont_periodo <= '0;
      largura      <= 3'd0;
      valido       <= 1'b0;
      pronto       <= 1'b0;
      erro         <= 1'b0;
      medida       <= '0;
      perda_sinal  <= 1'b0;
    end else begin
      s1     <= bus.pwm_in;
      s2     <= s1;
      s3     <= s2;
      pronto <= 1'b0;
      case (estado)
        INICIAL: begin
          if (rise) begin
            perda_sinal  <= 1'b0;
            cont_alto    <= 32'd1;
            cont_periodo <= 32'd1;
            estado       <= ALTO;
          end
        end
        ALTO: begin
          if (cont_periodo >= timeout) begin
            perda_sinal <= 1'b1;
            valido      <= 1'b0;
            estado      <= INICIAL;
          end else begin
            cont_periodo <= inc_sat(cont_periodo);
            if (fall) estado    <= BAIXO;
            else      cont_alto <= inc_sat(cont_alto);
          end
        end
        BAIXO: begin
          if (cont_periodo >= timeout) begin
            perda_sinal <= 1'b1;
            valido      <= 1'b0;
            estado      <= INICIAL;
          end else if (rise) begin
            medida <= cont_alto;
            pronto <= 1'b1;
            if (periodo_ok && casou) begin
              largura <= codigo;
              valido  <= 1'b1;
              erro    <= 1'b0;
            end else begin
              valido <= 1'b0;
              erro   <= 1'b1;
            end
            cont_alto    <= 32'd1;
            cont_periodo <= 32'd1;
            estado       <= ALTO;
          end else begin
            cont_periodo <= inc_sat(cont_periodo);
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign bus.largura     = largura;
  assign bus.valido      = valido;
  assign bus.pronto      = pronto;
  assign bus.erro        = erro;
  assign bus.medida      = medida;
  assign bus.perda_sinal = perda_sinal;

endmodule

// File: tb/tb_decodificador_pwm.sv
// Directed PWM periods push their expected decode; a monitor pops and compares on every pronto pulse.
module tb_decodificador_pwm;
  logic clock = 1'b0;
  logic reset;

  decodificador_pwm_if bus();

  decodificador_pwm #(
    .conf_periodo(32'd1000), .tol_periodo(32'd10),
    .largura_000(32'd100), .largura_001(32'd150), .largura_010(32'd200), .largura_011(32'd250),
    .largura_100(32'd300), .largura_101(32'd350), .largura_110(32'd400), .largura_111(32'd450),
    .tolerancia(32'd10), .timeout(32'd2000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  largura;
    logic        valido;
    logic        erro;
    logic [31:0] medida;
    int          ciclo;
  } esp_t;

  esp_t fila[$];
  esp_t e_mon;
  int   ciclo  = 0;
  int   passou = 0;
  int   total  = 0;

  always @(posedge clock) ciclo++;

  task automatic checar(input string nome, input logic [63:0] atual, input logic [63:0] exigido);
    total++;
    if (atual === exigido) passou++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, exigido, ciclo);
  endtask

  // Monitor: every pronto must match the oldest pending expectation, on the expected cycle.
  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      if (fila.size() == 0) begin
        total++;
        $display("FAIL pronto_inesperado: got pronto with medida=%0d at cycle %0d, expected none",
                 bus.medida, ciclo);
      end else begin
        e_mon = fila.pop_front();
        checar("decodificacao", 64'({bus.largura, bus.valido, bus.erro, bus.medida}),
               64'({e_mon.largura, e_mon.valido, e_mon.erro, e_mon.medida}));
        checar("latencia", 64'(ciclo), 64'(e_mon.ciclo));
      end
    end
  end

  // One period: 'alto' high cycles then low up to 'tot'. When 'fecha' is set the next rise
  // closes this period and must report the given code/flags with medida = alto.
  task automatic pulso(input int alto, input int tot, input bit fecha,
                       input logic [2:0] l, input bit v, input bit er);
    for (int i = 0; i < tot; i++) begin
      bus.pwm_in = (i < alto);
      @(posedge clock); #1;
    end
    if (fecha) fila.push_back('{l, v, er, 32'(alto), ciclo + 3});
  endtask

  task automatic ciclos(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    reset = 1'b1;
    bus.pwm_in = 1'b0;
    ciclos(3);
    checar("reset_inicial", 64'({bus.largura, bus.valido, bus.pronto, bus.erro, bus.medida, bus.perda_sinal}), 64'd0);
    reset = 1'b0;
    ciclos(5);

    // Test 1: three nominal 200/1000 periods, the first rise gives no pronto
    pulso(200, 1000, 1, 3'd2, 1, 0);
    pulso(200, 1000, 1, 3'd2, 1, 0);
    pulso(200, 1000, 1, 3'd2, 1, 0);
    // Test 2: in-tolerance 205, then 125 which sits between codes
    pulso(205, 1000, 1, 3'd2, 1, 0);
    pulso(125, 1000, 1, 3'd2, 0, 1);
    // Test 3: bad period, then a good one inside the period tolerance
    pulso(300, 900,  1, 3'd2, 0, 1);
    pulso(300, 1005, 1, 3'd4, 1, 0);

    // Test 4a: line held low after a rise
    pulso(150, 1000, 1, 3'd1, 1, 0);
    pulso(150, 1900, 0, 3'd0, 0, 0);
    checar("perda_antes_timeout", 64'(bus.perda_sinal), 64'd0);
    pulso(0, 200, 0, 3'd0, 0, 0);
    checar("perda_baixo", 64'({bus.perda_sinal, bus.valido, bus.largura}), 64'({1'b1, 1'b0, 3'd1}));
    pulso(200, 1000, 1, 3'd2, 1, 0);
    checar("retomada_baixo", 64'({bus.perda_sinal, bus.valido}), 64'({1'b0, 1'b0}));
    pulso(200, 1000, 1, 3'd2, 1, 0);
    // Test 4b: line held high
    pulso(2100, 2100, 0, 3'd0, 0, 0);
    checar("perda_alto", 64'({bus.perda_sinal, bus.valido, bus.largura}), 64'({1'b1, 1'b0, 3'd2}));
    pulso(0, 10, 0, 3'd0, 0, 0);
    pulso(200, 1000, 1, 3'd2, 1, 0);
    checar("retomada_alto", 64'({bus.perda_sinal, bus.valido}), 64'({1'b0, 1'b0}));

    // Test 5: reset 50 cycles into a high phase
    bus.pwm_in = 1'b1;
    ciclos(50);
    reset = 1'b1;
    #1;
    checar("reset_meio", 64'({bus.largura, bus.valido, bus.pronto, bus.erro, bus.medida, bus.perda_sinal}), 64'd0);
    bus.pwm_in = 1'b0;
    ciclos(3);
    reset = 1'b0;
    ciclos(5);
    pulso(200, 1000, 1, 3'd2, 1, 0);

    // Test 6: sweep all codes at their nominal widths
    for (int k = 0; k < 8; k++) pulso(100 + 50 * k, 1000, 1, 3'(k), 1, 0);
    pulso(50, 50, 0, 3'd0, 0, 0);
    ciclos(10);
    checar("fila_vazia", 64'(fila.size()), 64'd0);

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end
endmodule
